// File: rtl/ga_result_reader.sv
// rtl/ga_result_reader.sv - snapshots ga_top results on done and streams them as a checksummed byte frame
module ga_result_reader #(
  parameter int          CHROMOSOME_WIDTH = 16,
  parameter int          FITNESS_WIDTH    = 14,
  parameter logic [7:0]  HEADER_BYTE      = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        done,
  input  logic                        perfect_found,
  input  logic [CHROMOSOME_WIDTH-1:0] best_chromosome,
  input  logic [FITNESS_WIDTH-1:0]    best_fitness,
  input  logic [31:0]                 iteration_count,
  input  logic [31:0]                 crossovers_to_perfect,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_last,
  output logic                        busy,
  output logic [15:0]                 frames_sent,
  output logic [7:0]                  drop_count
);

  localparam int CB        = (CHROMOSOME_WIDTH + 7) / 8;
  localparam int FB        = (FITNESS_WIDTH + 7) / 8;
  localparam int NUM_BYTES = 2 + CB + FB + 4 + 4 + 1;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam int SNAP_W    = 1 + CHROMOSOME_WIDTH + FITNESS_WIDTH + 64;
  localparam int FRAME_W   = (NUM_BYTES - 1) * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [SNAP_W-1:0]   active_q, active_d;
  logic [SNAP_W-1:0]   pend_snap_q, pend_snap_d;
  logic                pending_q, pending_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]          csum_q, csum_d;
  logic                done_d_q, done_d_d;
  logic [15:0]         frames_q, frames_d;
  logic [7:0]          drop_q, drop_d;

  logic                trigger;
  logic                accept;
  logic                last_accept;
  logic [SNAP_W-1:0]   snap;
  logic [CB*8-1:0]     chr_ext;
  logic [FB*8-1:0]     fit_ext;
  logic [FRAME_W-1:0]  frame_vec;

  assign snap        = {perfect_found, best_chromosome, best_fitness, iteration_count, crossovers_to_perfect};
  assign trigger     = enable && done && !done_d_q;
  assign accept      = tx_valid && tx_ready;
  assign last_accept = accept && (byte_idx_q == LAST_IDX);

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      active_q    <= '0;
      pend_snap_q <= '0;
      pending_q   <= 1'b0;
      byte_idx_q  <= '0;
      csum_q      <= 8'h00;
      done_d_q    <= 1'b0;
      frames_q    <= 16'h0000;
      drop_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_snap_q <= pend_snap_d;
      pending_q   <= pending_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      done_d_q    <= done_d_d;
      frames_q    <= frames_d;
      drop_q      <= drop_d;
    end
  end

  // Next state: trigger handling, byte sequencing and pending-slot promotion
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_snap_d = pend_snap_q;
    pending_d   = pending_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    done_d_d    = done;
    frames_d    = frames_q;
    drop_d      = drop_q;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d    = S_SEND;
          active_d   = snap;
          byte_idx_d = '0;
          csum_d     = 8'h00;
        end
      end
      S_SEND: begin
        if (accept) begin
          csum_d     = csum_q ^ tx_data;
          byte_idx_d = byte_idx_q + IDX_W'(1);
        end
        if (last_accept) begin
          frames_d   = frames_q + 16'd1;
          byte_idx_d = '0;
          csum_d     = 8'h00;
          if (pending_q) begin
            // Pending frame goes next; a coincident trigger refills the slot
            active_d = pend_snap_q;
            if (trigger) begin
              pend_snap_d = snap;
            end else begin
              pending_d = 1'b0;
            end
          end else if (trigger) begin
            active_d = snap;
          end else begin
            state_d = S_IDLE;
          end
        end else if (trigger) begin
          pend_snap_d = snap;
          pending_d   = 1'b1;
          if (pending_q && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: frame byte selection from the active snapshot, status flags
  always_comb begin
    chr_ext = '0;
    chr_ext[CHROMOSOME_WIDTH-1:0] = active_q[64+FITNESS_WIDTH +: CHROMOSOME_WIDTH];
    fit_ext = '0;
    fit_ext[FITNESS_WIDTH-1:0] = active_q[64 +: FITNESS_WIDTH];
    frame_vec = {HEADER_BYTE, 7'b0, active_q[SNAP_W-1], chr_ext, fit_ext, active_q[63:0]};

    tx_valid = (state_q == S_SEND);
    tx_data  = 8'h00;
    if (tx_valid) begin
      if (byte_idx_q == LAST_IDX) begin
        tx_data = csum_q;
      end else begin
        for (int i = 0; i < NUM_BYTES - 1; i++) begin
          if (byte_idx_q == IDX_W'(i)) begin
            tx_data = frame_vec[FRAME_W-1-8*i -: 8];
          end
        end
      end
    end
    tx_last     = tx_valid && (byte_idx_q == LAST_IDX);
    busy        = (state_q == S_SEND) || pending_q;
    frames_sent = frames_q;
    drop_count  = drop_q;
  end

endmodule

// File: tb/tb_ga_result_reader.sv
// tb/tb_ga_result_reader.sv - directed self-checking bench for ga_result_reader
module tb_ga_result_reader;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        done;
  logic        perfect_found;
  logic [15:0] best_chromosome;
  logic [13:0] best_fitness;
  logic [31:0] iteration_count;
  logic [31:0] crossovers_to_perfect;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic [15:0] frames_sent;
  logic [7:0]  drop_count;

  int checks;
  int errors;
  int exp_frames;
  int exp_drops;

  logic [7:0] exp_a [15];
  logic [7:0] exp_c [15];

  ga_result_reader dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .done                  (done),
    .perfect_found         (perfect_found),
    .best_chromosome       (best_chromosome),
    .best_fitness          (best_fitness),
    .iteration_count       (iteration_count),
    .crossovers_to_perfect (crossovers_to_perfect),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .tx_last               (tx_last),
    .busy                  (busy),
    .frames_sent           (frames_sent),
    .drop_count            (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_snap_a();
    perfect_found = 1'b1; best_chromosome = 16'hFFFF; best_fitness = 14'h0010;
    iteration_count = 32'd20; crossovers_to_perfect = 32'd7;
  endtask

  task automatic set_snap_b();
    perfect_found = 1'b0; best_chromosome = 16'h1234; best_fitness = 14'h3FFF;
    iteration_count = 32'h01020304; crossovers_to_perfect = 32'hAABBCCDD;
  endtask

  task automatic set_snap_c();
    perfect_found = 1'b1; best_chromosome = 16'hBEEF; best_fitness = 14'h0001;
    iteration_count = 32'hDEADBEEF; crossovers_to_perfect = 32'h0;
  endtask

  // Called right after a negedge; collects nb accepted bytes and reports protocol anomalies
  task automatic collect(input int nb, input bit rnd, output logic [7:0] b [30],
                         output int last_err, output int stab_err, output int gaps, output bit tmo);
    int n;
    int cyc;
    logic pv, pr;
    logic [7:0] pd;
    n = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
    last_err = 0; stab_err = 0; gaps = 0; tmo = 1'b0;
    for (int i = 0; i < 30; i++) b[i] = 8'h00;
    while (n < nb && !tmo) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (pv && !pr && (!tx_valid || tx_data !== pd)) stab_err++;
      if (tx_valid) begin
        if (tx_last !== ((n % 15) == 14)) last_err++;
        if (tx_ready) begin
          b[n] = tx_data;
          n++;
        end
      end else if (n > 0) begin
        gaps++;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      cyc++;
      if (cyc > 400) tmo = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
        frames_sent !== 16'h0 || drop_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b data=%h busy=%b frames=%0d drops=%0d required all zero",
               tx_valid, tx_last, tx_data, busy, frames_sent, drop_count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_frame_check(input string name, input bit rnd);
    logic [7:0] b [30];
    int le, se, gp;
    bit tmo;
    tx_ready = 1'b1;
    set_snap_a();
    done = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL %s_valid_before_edge: got %b required 0", name, tx_valid);
    end
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL %s_latency: valid=%b data=%h required 1/a5", name, tx_valid, tx_data);
    end
    collect(15, rnd, b, le, se, gp, tmo);
    checks++;
    if (tmo) begin
      errors++; $display("FAIL %s_timeout: frame not completed in cycle budget, required completion", name);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (b[i] !== exp_a[i]) begin
        errors++; $display("FAIL %s_byte%0d: got %h required %h", name, i, b[i], exp_a[i]);
      end
    end
    checks++;
    if (le != 0) begin
      errors++; $display("FAIL %s_tx_last: %0d misplaced, required 0", name, le);
    end
    checks++;
    if (se != 0) begin
      errors++; $display("FAIL %s_stability: %0d changes under backpressure, required 0", name, se);
    end
    exp_frames++;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || frames_sent !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL %s_after: busy=%b valid=%b frames=%0d required 0/0/%0d", name, busy, tx_valid, frames_sent, exp_frames);
    end
  endtask

  task automatic test_basic();
    run_frame_check("basic", 1'b0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    run_frame_check("backpressure", 1'b1);
  endtask

  task automatic test_simultaneous();
    logic [7:0] b [30];
    int le, se, gp, cyc;
    bit tmo;
    @(negedge clk);
    tx_ready = 1'b1;
    set_snap_a();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    cyc = 0;
    while (!(tx_valid && tx_last) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 40) begin
      errors++; $display("FAIL simul_reach_last: last byte not seen in 40 cycles, required it");
    end
    set_snap_c();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    exp_frames++;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      errors++; $display("FAIL simul_restart: valid=%b data=%h busy=%b required 1/a5/1", tx_valid, tx_data, busy);
    end
    collect(15, 1'b0, b, le, se, gp, tmo);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (b[i] !== exp_c[i]) begin
        errors++; $display("FAIL simul_byte%0d: got %h required %h", i, b[i], exp_c[i]);
      end
    end
    exp_frames++;
    checks++;
    if (drop_count !== 8'(exp_drops) || frames_sent !== 16'(exp_frames) || tmo) begin
      errors++;
      $display("FAIL simul_counts: drops=%0d frames=%0d tmo=%b required %0d/%0d/0", drop_count, frames_sent, tmo, exp_drops, exp_frames);
    end
  endtask

  task automatic test_pending_drop();
    logic [7:0] b [30];
    int le, se, gp;
    bit tmo;
    @(negedge clk);
    tx_ready = 1'b0;
    set_snap_a(); done = 1'b1; @(negedge clk); done = 1'b0; @(negedge clk);
    set_snap_b(); done = 1'b1; @(negedge clk); done = 1'b0; @(negedge clk);
    set_snap_c(); done = 1'b1; @(negedge clk); done = 1'b0; @(negedge clk);
    exp_drops++;
    checks++;
    if (drop_count !== 8'(exp_drops) || busy !== 1'b1 || tx_data !== 8'hA5 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL pend_drop: drops=%0d busy=%b data=%h valid=%b required %0d/1/a5/1", drop_count, busy, tx_data, tx_valid, exp_drops);
    end
    collect(30, 1'b0, b, le, se, gp, tmo);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (b[i] !== exp_a[i]) begin
        errors++; $display("FAIL pend_first_byte%0d: got %h required %h", i, b[i], exp_a[i]);
      end
      checks++;
      if (b[15+i] !== exp_c[i]) begin
        errors++; $display("FAIL pend_second_byte%0d: got %h required %h", i, b[15+i], exp_c[i]);
      end
    end
    checks++;
    if (gp != 0 || le != 0 || tmo) begin
      errors++; $display("FAIL pend_b2b: gaps=%0d last_err=%0d tmo=%b required 0/0/0", gp, le, tmo);
    end
    exp_frames += 2;
    checks++;
    if (frames_sent !== 16'(exp_frames) || busy !== 1'b0) begin
      errors++; $display("FAIL pend_frames: frames=%0d busy=%b required %0d/0", frames_sent, busy, exp_frames);
    end
  endtask

  task automatic test_enable_level();
    int vcount, acc;
    @(negedge clk);
    tx_ready = 1'b1;
    enable = 1'b0;
    set_snap_b();
    done = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) vcount++;
    end
    done = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    checks++;
    if (vcount != 0 || frames_sent !== 16'(exp_frames)) begin
      errors++; $display("FAIL enable_off: valid cycles=%0d frames=%0d required 0/%0d", vcount, frames_sent, exp_frames);
    end
    @(negedge clk);
    done = 1'b1;
    acc = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 100) done = 1'b0;
      if (tx_valid && tx_ready) acc++;
    end
    exp_frames++;
    checks++;
    if (acc != 15 || frames_sent !== 16'(exp_frames)) begin
      errors++; $display("FAIL level_done: bytes=%0d frames=%0d required 15/%0d", acc, frames_sent, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, cyc, vcount;
    @(negedge clk);
    tx_ready = 1'b1;
    set_snap_a();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n = 0; cyc = 0;
    while (!(tx_valid && n == 6) && cyc < 40) begin
      if (tx_valid) n++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_a[6]) begin
      errors++; $display("FAIL rstmid_byte6: valid=%b data=%h required 1/%h", tx_valid, tx_data, exp_a[6]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
        frames_sent !== 16'h0 || drop_count !== 8'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: valid=%b last=%b data=%h busy=%b frames=%0d drops=%0d required all zero",
               tx_valid, tx_last, tx_data, busy, frames_sent, drop_count);
    end
    @(negedge clk);
    rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_valid) vcount++;
    end
    checks++;
    if (vcount != 0 || frames_sent !== 16'h0) begin
      errors++; $display("FAIL rstmid_quiet: valid cycles=%0d frames=%0d required 0/0", vcount, frames_sent);
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_frames = 0; exp_drops = 0;
    exp_a = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h14,
              8'h00, 8'h00, 8'h00, 8'h07, 8'hA7};
    exp_c = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h00, 8'h00, 8'h00, 8'h00, 8'hD6};
    rst = 1'b0; enable = 1'b1; done = 1'b0; tx_ready = 1'b0;
    perfect_found = 1'b0; best_chromosome = '0; best_fitness = '0;
    iteration_count = '0; crossovers_to_perfect = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_pending_drop();
    test_enable_level();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ga_result_reader.md
Name: ga_result_reader

Overview:
- Output-side reader for ga_top; the counterpart of the block that writes the initial population into the GA.
- On each completed GA run (rising edge of done), snapshots the result outputs of ga_top and streams them as a fixed-format byte frame over a valid/ready stream to a host link (UART/FIFO bridge).
- Holds one pending snapshot so that back-to-back runs are not lost while a frame is in flight.

Parameters:
- CHROMOSOME_WIDTH, 16, width of best_chromosome
- FITNESS_WIDTH, 14, width of best_fitness
- HEADER_BYTE, 8'hA5, first byte of every frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  when 0, done edges are ignored; a frame already in flight completes
- done  in  1  ga_top done
- perfect_found  in  1  ga_top perfect_found
- best_chromosome  in  CHROMOSOME_WIDTH  ga_top best_chromosome
- best_fitness  in  FITNESS_WIDTH  ga_top best_fitness
- iteration_count  in  32  ga_top iteration_count
- crossovers_to_perfect  in  32  ga_top crossovers_to_perfect
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts when tx_valid && tx_ready at a clk edge
- tx_last  out  1  high with the checksum byte
- busy  out  1  frame in flight or snapshot pending
- frames_sent  out  16  completed frames; wraps 0xFFFF->0
- drop_count  out  8  overwritten pending snapshots; saturates at 255

Behaviour:
- Reset (rst=0, async): state IDLE; tx_valid=0, tx_last=0, tx_data=0, busy=0, frames_sent=0, drop_count=0, pending=0, done_d=0. Reset mid-frame abandons the frame; no partial completion after release.
- Trigger: edge = enable && done && !done_d; done_d is registered every cycle regardless of enable.
- Snapshot = {perfect_found, best_chromosome, best_fitness, iteration_count, crossovers_to_perfect}, sampled at the same clk edge that sees the trigger.
- Frame, CB = ceil(CHROMOSOME_WIDTH/8), FB = ceil(FITNESS_WIDTH/8); all fields MSB byte first, zero-extended to whole bytes:
  - byte 0: HEADER_BYTE
  - byte 1: flags {7'b0, perfect_found}
  - CB chromosome bytes
  - FB fitness bytes
  - 4 iteration_count bytes
  - 4 crossovers_to_perfect bytes
  - checksum byte = XOR of all preceding bytes, header included
  - Defaults give 15 bytes (indices 0..14).
- States: IDLE, SEND.
  - IDLE: on trigger, capture snapshot into the active register, byte_idx=0, checksum=0, go to SEND. tx_valid rises on that edge, i.e. 1 cycle after done is first sampled high.
  - SEND: tx_data is a function of active snapshot, byte_idx and checksum. It stays stable while tx_valid && !tx_ready. On accept, checksum ^= tx_data and byte_idx++.
  - SEND, accept of last byte: frames_sent++. If pending, promote pending to active, reset byte_idx and checksum, stay in SEND with tx_valid held high (back-to-back, no idle cycle). Otherwise go to IDLE with tx_valid=0.
- Trigger while in SEND:
  - pending=0: snapshot goes to pending and pending is set.
  - pending=1: pending is overwritten and drop_count++ (saturating).
- Simultaneous trigger and last-byte accept:
  - pending=0: trigger goes straight to active; stay in SEND; no drop.
  - pending=1: pending is promoted to active, trigger goes to pending; no drop.
- tx_last = tx_valid && (byte_idx == last index).
- busy = (state==SEND) || pending.
- done held high for many cycles produces exactly one trigger.
- enable=0 with a frame in flight: the frame and any pending frame still complete.
- tx_ready may be held low indefinitely; no timeout.

Test Plan:
- Basic frame: perfect=1, chr=16'hFFFF, fit=14'h0010, iter=20, xo=7, done 0->1, tx_ready=1 -> tx_valid rises 1 cycle later; 15 bytes A5,01,FF,FF,00,10,00,00,00,14,00,00,00,07,checksum; tx_last only on byte 14; checksum equals XOR of bytes 0..13; frames_sent=1; busy low after the last byte.
- Backpressure: toggle tx_ready in a pseudo-random pattern with ~50% duty -> identical byte sequence to the basic frame; tx_data never changes while tx_valid && !tx_ready.
- Pending and drop: three done pulses during one frame with tx_ready=0 -> drop_count=1; after release, two frames: the first snapshot, then the third; frames_sent=2; second frame starts with no idle cycle.
- Simultaneous: done edge coincides with the last-byte accept, no pending -> next cycle tx_data=A5 carrying the new snapshot; drop_count=0.
- Enable and level: enable=0 on a done edge -> no frame. Hold done high for 100 cycles with enable=1 -> exactly one frame.
- Reset mid-frame: assert rst=0 at byte 6 -> outputs go to reset values immediately; after release, no bytes until the next done edge.
